// File: rtl/alu_result_uart_tx_if.sv
// Valid/ready handshake bundle carrying one registered ALU result and its flags.
interface alu_result_uart_tx_if;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic [2:0] opcode;

  modport master (
    output res_valid,
    output result,
    output carry_out,
    output overflow,
    output opcode,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  result,
    input  carry_out,
    input  overflow,
    input  opcode,
    output res_ready
  );
endinterface

// File: rtl/alu_result_uart_tx.sv
// Captures ALU results through a one-entry holding register and sends each one
// as a two-byte UART 8N1 frame: {marker, opcode, 00, carry, overflow}, then result.
module alu_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_uart_tx_if.slave  alu,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DONE_CNT = 16'(CLKS_PER_BIT - 2);

  state_t      state;
  logic        hold_full;
  logic [12:0] hold_data;
  logic        ready_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  byte1_buf;
  logic        byte_sel;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic        accept;
  logic        bit_end;

  assign alu.res_ready = ready_reg;
  assign accept        = alu.res_valid && ready_reg;
  assign bit_end       = (baud_cnt == LAST_CNT);

  // hold_data layout: [12:10] opcode, [9] carry_out, [8] overflow, [7:0] result.
  // ready_reg always mirrors !hold_full, so accept and load never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      ready_reg  <= 1'b1;
      shift_reg  <= '0;
      byte1_buf  <= '0;
      byte_sel   <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        hold_full <= 1'b1;
        ready_reg <= 1'b0;
        hold_data <= {alu.opcode, alu.carry_out, alu.overflow, alu.result};
      end

      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (hold_full) begin
            shift_reg <= {1'b1, hold_data[12:10], 2'b00, hold_data[9], hold_data[8]};
            byte1_buf <= hold_data[7:0];
            hold_full <= 1'b0;
            ready_reg <= 1'b1;
            byte_sel  <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end else begin
            busy <= accept;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        STOP: begin
          // Raise frame_done one edge early so the registered pulse lands on the final stop cycle.
          if (byte_sel && baud_cnt == DONE_CNT) begin
            frame_done <= 1'b1;
          end
          if (bit_end) begin
            baud_cnt <= '0;
            if (!byte_sel) begin
              byte_sel  <= 1'b1;
              shift_reg <= byte1_buf;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= hold_full || accept;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
